instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Fetch stage upstream of control_unit. Owns the PC and issues word reads to a variable-latency instruction memory.
//  Buffers returned words in a DEPTH-entry FIFO and presents the head as Instr plus split fields (Cond/Op/Funct/Rd).
//  Takes the taken-branch redirect (PCSrc + target) from the datapath and flushes queued/in-flight words.
// PARAMETERS
//  DEPTH    2      FIFO entries (>=1); each entry holds {instr[31:0], pc[31:0]}
//  RESET_PC 32'h0  fetch address after reset (word aligned)
// PORTS
//  CLK           in   1   clock, rising edge
//  Reset         in   1   asynchronous, active-high reset
//  imem_req      out  1   read request; registered
//  imem_addr     out  32  read address; word aligned; stable while imem_req=1
//  imem_ack      in   1   read data valid this cycle; only meaningful while imem_req=1
//  imem_rdata    in   32  read data, sampled when imem_req&imem_ack
//  instr_valid   out  1   FIFO head valid (FIFO not empty)
//  instr_ready   in   1   consumer takes head this cycle
//  Instr         out  32  head instruction; 32'h0 when empty
//  Cond/Op/Funct/Rd out 4/2/6/4  Instr[31:28]/[27:26]/[25:20]/[15:12]
//  PCPlus8       out  32  head PC + 8 (ARM R15 read value), modulo 2^32; 0 when empty
//  PCSrc         in   1   redirect pulse; has priority over every other event in that cycle
//  BranchTarget  in   32  redirect address; bits [1:0] forced to 0
// BEHAVIOUR
//  Reset (async): imem_req=0, imem_addr=RESET_PC, FIFO empty, instr_valid=0, Instr/fields/PCPlus8=0,
//   fetch_pc=RESET_PC, state=IDLE; an in-flight request is abandoned (memory side must tolerate req dropping).
//  Pop = instr_valid & instr_ready. Push = imem_req & imem_ack & state==WAIT & ~PCSrc; push stores {imem_rdata, imem_addr}.
//  Push and pop in the same cycle: count unchanged; pop from empty is ignored.
//  space = (count - pop) < DEPTH, evaluated before the push this cycle.
//  FSM (one outstanding request max):
//   IDLE: if PCSrc -> flush, fetch_pc=target, stay IDLE. Else if space -> WAIT, imem_req=1, imem_addr=fetch_pc.
//   WAIT: req held, addr stable until ack.
//    ack & ~PCSrc -> push, fetch_pc+=4. If (count+1-pop)<DEPTH, stay WAIT with imem_addr=fetch_pc+4
//     (back-to-back: 1 instr/cycle with zero-wait memory); else -> IDLE, imem_req=0.
//    ack & PCSrc  -> data dropped, flush, fetch_pc=target, -> IDLE, imem_req=0.
//    ~ack & PCSrc -> flush, fetch_pc=target, -> DISCARD (req stays high, addr unchanged).
//   DISCARD: on ack drop data, imem_req=0 -> IDLE. A further PCSrc here updates fetch_pc only.
//  Flush: count=0 and instr_valid=0 on the next edge; a pop in the same cycle as PCSrc is still a legal
//   consume (the branch itself).
//  Latency: reset release -> first edge imem_req=1; zero-wait ack -> instr_valid after 2nd edge.
//   Redirect -> first target word valid >= 2 edges later (+ discard wait).
//  fetch_pc wraps 32'hFFFF_FFFC -> 0.
// TESTING
//  1 Zero-wait mem returning rdata=addr, instr_ready=1 -> Instr 0,4,8,... one per cycle, PCPlus8 = 8,12,16; req stays high.
//  2 instr_ready=0 from reset -> two entries (PCs 0,4) queued, imem_req=0, instr_valid stays 1;
//    ready=1 -> in-order drain, fetching resumes at 8.
//  3 3-cycle ack latency; PCSrc=1, target 0x100 one cycle after req@0x8 -> DISCARD; rdata@0x8 dropped;
//    next valid Instr has PCPlus8=0x108.
//  4 PCSrc and ack in the same cycle, target 0x40 -> no push, state IDLE, next req addr 0x40; instr_valid=0 next cycle.
//  5 Reset asserted mid-WAIT with FIFO holding 1 entry -> imem_req=0, instr_valid=0 immediately;
//    refetch from RESET_PC after release.
//  6 BranchTarget=0x103 -> imem_addr=0x100. fetch_pc at 0xFFFFFFFC -> next addr 0x0.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory read port, consumer handshake and branch redirect.
// The master side is the fetch queue. The slave side is the memory/consumer/datapath environment.
interface instr_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr;
    logic [3:0]  Cond;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rd;
    logic [31:0] PCPlus8;
    logic        PCSrc;
    logic [31:0] BranchTarget;

    modport master (
        output imem_req, imem_addr, instr_valid, Instr, Cond, Op, Funct, Rd, PCPlus8,
        input  imem_ack, imem_rdata, instr_ready, PCSrc, BranchTarget
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, Instr, Cond, Op, Funct, Rd, PCPlus8,
        output imem_ack, imem_rdata, instr_ready, PCSrc, BranchTarget
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, keeps at most one memory read outstanding and buffers returned words.
// A redirect flushes the queue. A read already in flight is either dropped on ack or left to drain in DISCARD.
//   state     | meaning
//   S_IDLE    | no request outstanding; launch one when the queue has room
//   S_WAIT    | request outstanding; the returned word is pushed into the queue
//   S_DISCARD | request outstanding after a redirect; the returned word is dropped
module instr_fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                CLK,
    input  logic                Reset,
    instr_fetch_queue_if.master bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_after_pop;
    logic          head_valid, pop, push, flush;
    logic [31:0]   target, head_instr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_valid      = (count_q != '0);
    assign pop             = head_valid & bus.instr_ready;
    assign count_after_pop = count_q - CW'(pop);
    assign target          = {bus.BranchTarget[31:2], 2'b00};

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    instr_mem_q[wr_ptr_q] <= bus.imem_rdata;
                    pc_mem_q[wr_ptr_q]    <= addr_q;
                    wr_ptr_q              <= ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                count_q <= count_after_pop + CW'(push);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.PCSrc) begin
                    flush      = 1'b1;
                    fetch_pc_d = target;
                end else if (count_after_pop < CW'(DEPTH)) begin
                    state_d = S_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (bus.imem_ack && bus.PCSrc) begin
                    flush      = 1'b1;
                    fetch_pc_d = target;
                    state_d    = S_IDLE;
                end else if (bus.imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = addr_q + 32'd4;
                    // keep streaming only if the word being pushed still leaves a free slot
                    if (count_after_pop < CW'(DEPTH - 1)) begin
                        addr_d = addr_q + 32'd4;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (bus.PCSrc) begin
                    flush      = 1'b1;
                    fetch_pc_d = target;
                    state_d    = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (bus.PCSrc) begin
                    flush      = 1'b1;
                    fetch_pc_d = target;
                end
                if (bus.imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req    = (state_q != S_IDLE);
        bus.imem_addr   = addr_q;
        bus.instr_valid = head_valid;
        head_instr      = '0;
        bus.PCPlus8     = '0;
        if (head_valid) begin
            head_instr  = instr_mem_q[rd_ptr_q];
            bus.PCPlus8 = pc_mem_q[rd_ptr_q] + 32'd8;
        end
        bus.Instr = head_instr;
        bus.Cond  = head_instr[31:28];
        bus.Op    = head_instr[27:26];
        bus.Funct = head_instr[25:20];
        bus.Rd    = head_instr[15:12];
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: vector table from reset, hand-written redirect/reset corner cases,
// then random traffic checked against an in-order instruction-stream model.
module tb_instr_fetch_queue;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    instr_fetch_queue_if bus();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int mem_wait = 0;
    int mem_lat = 0;
    bit rand_lat = 1'b0;
    bit scramble = 1'b0;

    typedef struct {
        bit          ready;
        bit          valid;
        logic [31:0] instr;
        logic [31:0] pcp8;
        bit          req;
        logic [31:0] addr;
    } vec_t;
    vec_t vecs [11];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return scramble ? {a[15:0], ~a[15:0]} : a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within cycle budget at %0t", name, $time);
    endtask

    task automatic drive_mem();
        bus.imem_ack   = bus.imem_req && (mem_wait >= mem_lat);
        bus.imem_rdata = mem_word(bus.imem_addr);
    endtask

    // One clock: memory wait counter restarts on a new request or after an ack.
    task automatic tick();
        logic req_pre, ack_pre;
        req_pre = bus.imem_req;
        ack_pre = bus.imem_ack;
        @(posedge CLK);
        @(negedge CLK);
        if (!bus.imem_req || !req_pre || ack_pre) begin
            mem_wait = 0;
            if (rand_lat) mem_lat = $urandom_range(0, 3);
        end else begin
            mem_wait++;
        end
        drive_mem();
    endtask

    task automatic reset_on(input int lat);
        Reset            = 1'b1;
        bus.PCSrc        = 1'b0;
        bus.BranchTarget = 32'h0;
        bus.instr_ready  = 1'b0;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = 32'h0;
        mem_lat          = lat;
        mem_wait         = 0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic reset_off();
        Reset    = 1'b0;
        mem_wait = 0;
        drive_mem();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        int          occ, pops;
        bit          discard, prev_req, prev_ack, req_n, ack_n, pop_n, push_n;
        logic [31:0] exp_pc, prev_addr, tgt, w;

        // ready | valid instr pcplus8 req addr  (zero-wait memory, rdata = addr)
        vecs[0]  = '{1'b0, 1'b0, 32'd0,  32'd0,  1'b1, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'd0,  32'd8,  1'b1, 32'd4};
        vecs[2]  = '{1'b0, 1'b1, 32'd0,  32'd8,  1'b0, 32'd4};
        vecs[3]  = '{1'b0, 1'b1, 32'd0,  32'd8,  1'b0, 32'd4};
        vecs[4]  = '{1'b1, 1'b1, 32'd4,  32'd12, 1'b1, 32'd8};
        vecs[5]  = '{1'b1, 1'b1, 32'd8,  32'd16, 1'b1, 32'd12};
        vecs[6]  = '{1'b1, 1'b1, 32'd12, 32'd20, 1'b1, 32'd16};
        vecs[7]  = '{1'b1, 1'b1, 32'd16, 32'd24, 1'b1, 32'd20};
        vecs[8]  = '{1'b0, 1'b1, 32'd16, 32'd24, 1'b0, 32'd20};
        vecs[9]  = '{1'b1, 1'b1, 32'd20, 32'd28, 1'b1, 32'd24};
        vecs[10] = '{1'b1, 1'b1, 32'd24, 32'd32, 1'b1, 32'd28};

        reset_on(0);
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_addr",  bus.imem_addr, RESET_PC);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.Instr, 32'd0);
        chk("rst_pcp8",  bus.PCPlus8, 32'd0);
        chk("rst_fields", 32'({bus.Cond, bus.Op, bus.Funct, bus.Rd}), 32'd0);
        reset_off();

        for (int i = 0; i < 11; i++) begin
            bus.instr_ready = vecs[i].ready;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_instr", i), bus.Instr, vecs[i].instr);
            chk($sformatf("vec%0d_pcp8", i),  bus.PCPlus8, vecs[i].pcp8);
            chk($sformatf("vec%0d_req", i),   32'(bus.imem_req), 32'(vecs[i].req));
            chk($sformatf("vec%0d_addr", i),  bus.imem_addr, vecs[i].addr);
        end

        // Redirect while a 3-cycle read of 0x8 is pending: the word must be discarded.
        reset_on(3);
        reset_off();
        bus.instr_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.imem_req && bus.imem_addr == 32'h8) begin found = 1'b1; break; end
        end
        if (!found) timeout("t3_req8");
        tick();
        bus.PCSrc        = 1'b1;
        bus.BranchTarget = 32'h100;
        tick();
        bus.PCSrc = 1'b0;
        chk("t3_discard_req",   32'(bus.imem_req), 32'd1);
        chk("t3_discard_addr",  bus.imem_addr, 32'h8);
        chk("t3_discard_valid", 32'(bus.instr_valid), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!bus.imem_req) begin found = 1'b1; break; end
        end
        if (!found) timeout("t3_req_drop");
        found = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.instr_valid) begin found = 1'b1; break; end
        end
        if (!found) timeout("t3_target_valid");
        chk("t3_pcp8",  bus.PCPlus8, 32'h108);
        chk("t3_instr", bus.Instr, 32'h100);

        // Redirect in the same cycle as an ack, with one word already queued.
        reset_on(2);
        reset_off();
        bus.instr_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.imem_req && bus.imem_ack && bus.instr_valid) begin found = 1'b1; break; end
        end
        if (!found) timeout("t4_ack_with_entry");
        bus.PCSrc        = 1'b1;
        bus.BranchTarget = 32'h40;
        tick();
        bus.PCSrc = 1'b0;
        chk("t4_req_idle", 32'(bus.imem_req), 32'd0);
        chk("t4_flushed",  32'(bus.instr_valid), 32'd0);
        chk("t4_instr0",   bus.Instr, 32'd0);
        tick();
        chk("t4_req_new",  32'(bus.imem_req), 32'd1);
        chk("t4_addr_new", bus.imem_addr, 32'h40);

        // Reset asserted mid-WAIT with one queued entry.
        reset_on(0);
        reset_off();
        bus.instr_ready = 1'b0;
        tick();
        tick();
        chk("t5_pre_valid", 32'(bus.instr_valid), 32'd1);
        chk("t5_pre_req",   32'(bus.imem_req), 32'd1);
        Reset = 1'b1;
        #1;
        chk("t5_async_req",   32'(bus.imem_req), 32'd0);
        chk("t5_async_valid", 32'(bus.instr_valid), 32'd0);
        chk("t5_async_instr", bus.Instr, 32'd0);
        @(negedge CLK);
        reset_off();
        tick();
        chk("t5_refetch_req",  32'(bus.imem_req), 32'd1);
        chk("t5_refetch_addr", bus.imem_addr, RESET_PC);

        // Target alignment and PC wrap at the top of the address space.
        reset_on(0);
        reset_off();
        bus.instr_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.PCSrc        = 1'b1;
        bus.BranchTarget = 32'h103;
        tick();
        bus.PCSrc = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (bus.imem_req) begin found = 1'b1; break; end
            tick();
        end
        if (!found) timeout("t6_req_after_redirect");
        chk("t6_aligned_addr", bus.imem_addr, 32'h100);
        bus.PCSrc        = 1'b1;
        bus.BranchTarget = 32'hFFFF_FFFE;
        tick();
        bus.PCSrc = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.imem_req && bus.imem_addr == 32'hFFFF_FFFC) begin found = 1'b1; break; end
            tick();
        end
        if (!found) timeout("t6_req_top");
        tick();
        chk("t6_wrap_addr",  bus.imem_addr, 32'h0);
        chk("t6_wrap_instr", bus.Instr, 32'hFFFF_FFFC);
        chk("t6_wrap_pcp8",  bus.PCPlus8, 32'h4);

        // Random traffic. The model is the architectural stream: the head is always the next PC in
        // program order, restarting at the target after every redirect.
        reset_on(0);
        rand_lat = 1'b1;
        scramble = 1'b1;
        reset_off();
        occ = 0; pops = 0; discard = 1'b0;
        exp_pc = RESET_PC;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            chk("rnd_valid", 32'(bus.instr_valid), 32'(occ > 0));
            if (occ > 0) begin
                w = mem_word(exp_pc);
                chk("rnd_instr",  bus.Instr, w);
                chk("rnd_pcp8",   bus.PCPlus8, exp_pc + 32'd8);
                chk("rnd_fields", 32'({bus.Cond, bus.Op, bus.Funct, bus.Rd}), 32'({w[31:20], w[15:12]}));
            end else begin
                chk("rnd_empty_instr", bus.Instr, 32'd0);
                chk("rnd_empty_pcp8",  bus.PCPlus8, 32'd0);
            end
            if (prev_req && !prev_ack && bus.imem_req)
                chk("rnd_addr_stable", bus.imem_addr, prev_addr);

            bus.instr_ready = ($urandom_range(0, 9) < 7);
            bus.PCSrc       = ($urandom_range(0, 24) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            bus.BranchTarget = tgt;

            req_n  = bus.imem_req;
            ack_n  = bus.imem_ack;
            pop_n  = (occ > 0) && bus.instr_ready;
            push_n = req_n && ack_n && !bus.PCSrc && !discard;
            if (push_n) chk("rnd_push_addr", bus.imem_addr, exp_pc + 32'(4 * occ));
            if (pop_n) pops++;
            if (bus.PCSrc) begin
                occ    = 0;
                exp_pc = tgt & ~32'h3;
                if (req_n && !ack_n) discard = 1'b1;
            end else begin
                if (pop_n) begin occ--; exp_pc = exp_pc + 32'd4; end
                if (push_n) occ++;
            end
            if (req_n && ack_n) discard = 1'b0;
            prev_req  = req_n;
            prev_ack  = ack_n;
            prev_addr = bus.imem_addr;
            tick();
        end
        chk("rnd_throughput", 32'(pops > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
